// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, state enum and error check for the load/store unit
package lsu_pkg;

  // Access size field lsu_op[1:0]
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  // Flag bit positions inside lsu_op
  localparam int OP_UNS = 2;
  localparam int OP_ST  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RESP = 2'b10
  } state_t;

  // High when the op must not reach the bus: illegal size or misaligned address
  function automatic logic op_bad(input logic [3:0] op, input logic [1:0] addr_lo);
    logic bad;
    case (op[1:0])
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane steering/byte mask and load extract/extend
module lsu_align
  import lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_mask,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Replicate store data across lanes and enable only the addressed bytes
  always_comb begin
    lane_wdata = wdata;
    lane_mask  = 4'b0000;
    case (op[1:0])
      SZ_B: begin
        lane_wdata = {4{wdata[7:0]}};
        lane_mask  = 4'b0001 << addr_lo;
      end
      SZ_H: begin
        lane_wdata = {2{wdata[15:0]}};
        lane_mask  = 4'b0011 << addr_lo;
      end
      default: begin
        lane_wdata = wdata;
        lane_mask  = 4'b1111;
      end
    endcase
    if (!op[OP_ST]) begin
      lane_mask = 4'b0000;
    end
  end

  // Pick the addressed byte/half out of the read word and extend it
  always_comb begin
    byte_v    = 8'(rdata >> {addr_lo, 3'b000});
    half_v    = 16'(rdata >> {addr_lo[1], 4'b0000});
    load_data = rdata;
    case (op[1:0])
      SZ_B:    load_data = op[OP_UNS] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_H:    load_data = op[OP_UNS] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit between execute and write-back
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [3:0]        lsu_op,
  input  logic [4:0]        rd_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_rd,
  output logic              out_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        op_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  logic              accept;
  logic              capture;
  logic [31:0]       lane_wdata;
  logic [3:0]        lane_mask;
  logic [31:0]       load_data;

  lsu_align u_align (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .lane_wdata (lane_wdata),
    .lane_mask  (lane_mask),
    .load_data  (load_data)
  );

  // State register; reset drops mem_req at once since it decodes from state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    mem_req   = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = op_bad(lsu_op, addr_in[1:0]) ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operation latches; result starts at zero so stores and errors report 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= addr_in;
      wdata_q <= wdata_in;
      op_q    <= lsu_op;
      rd_q    <= rd_in;
      data_q  <= '0;
      err_q   <= op_bad(lsu_op, addr_in[1:0]);
    end else if (capture && !op_q[OP_ST]) begin
      data_q <= load_data;
    end
  end

  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = lane_wdata;
  assign mem_we    = mem_req & op_q[OP_ST];
  assign mem_wmask = mem_req ? lane_mask : 4'b0000;
  assign out_data  = data_q;
  assign out_rd    = rd_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - scoreboard bench for the load/store unit
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] addr_in = '0;
  logic [31:0] wdata_in = '0;
  logic [3:0]  lsu_op = '0;
  logic [4:0]  rd_in = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_err;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .lsu_op    (lsu_op),
    .rd_in     (rd_in),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic m_err(input logic [3:0] op, input logic [31:0] a);
    case (op[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return (a[1:0] != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] m_mask(input logic [3:0] op, input logic [31:0] a);
    if (!op[3]) return 4'b0000;
    case (op[1:0])
      2'b00:   case (a[1:0]) 2'd0: return 4'b0001; 2'd1: return 4'b0010;
                             2'd2: return 4'b0100; default: return 4'b1000; endcase
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] wd);
    case (op[1:0])
      2'b00:   return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      2'b01:   return {wd[15:0], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (op[1:0])
      2'b00:   return op[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return op[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: return rd;
    endcase
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] op,
                        input logic [4:0] rd, input logic [31:0] rdata, input int waits, input int hold);
    exp_t e;
    exp_t got;
    logic err;
    err    = m_err(op, a);
    e.err  = err;
    e.rd   = rd;
    e.data = (err || op[3]) ? 32'h0 : m_load(op, a, rdata);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    addr_in  = a;
    wdata_in = wd;
    lsu_op   = op;
    rd_in    = rd;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    addr_in  = $urandom;
    wdata_in = $urandom;
    lsu_op   = 4'($urandom);
    rd_in    = 5'($urandom);
    if (!err) begin
      for (int w = 0; w <= waits; w++) begin
        check("mem_req", mem_req, 1);
        check("mem_addr", mem_addr, {a[31:2], 2'b00});
        check("mem_we", mem_we, op[3]);
        check("mem_wmask", mem_wmask, m_mask(op, a));
        if (op[3]) check("mem_wdata", mem_wdata, m_wdata(op, wd));
        check("in_ready_busy", in_ready, 0);
        check("out_valid_early", out_valid, 0);
        if (w == waits) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end else begin
          mem_rdata = $urandom;
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      check("err_no_req", mem_req, 0);
    end
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, e.data);
      check("hold_err", out_err, e.err);
      check("hold_in_ready", in_ready, 0);
      check("hold_no_req", mem_req, 0);
      mem_ack   = 1'b1;
      mem_rdata = ~rdata;
      @(negedge clk);
      mem_ack = 1'b0;
    end
    check("out_valid", out_valid, 1);
    out_ready = 1'b1;
    got = {out_data, out_rd, out_err};
    e   = sb.pop_front();
    check("out_data", got.data, e.data);
    check("out_rd", got.rd, e.rd);
    check("out_err", got.err, e.err);
    @(negedge clk);
    out_ready = 1'b0;
    check("done_valid", out_valid, 0);
    check("done_in_ready", in_ready, 1);
  endtask

  initial begin
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_err", out_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h8000_0004, 32'h0,          4'b0010, 5'd1,  32'hDEAD_BEEF, 0, 0);
    run_op(32'h8000_0003, 32'h0,          4'b0000, 5'd2,  32'h8012_3456, 0, 0);
    run_op(32'h8000_0003, 32'h0,          4'b0100, 5'd3,  32'h8012_3456, 0, 0);
    run_op(32'h8000_0002, 32'h1234_ABCD,  4'b1001, 5'd4,  32'h0,         0, 0);
    run_op(32'h8000_0001, 32'h0,          4'b0010, 5'd5,  32'h0,         0, 0);
    run_op(32'h8000_0000, 32'h0,          4'b0011, 5'd6,  32'h0,         0, 1);
    run_op(32'h8000_0003, 32'h5555_AAAA,  4'b1001, 5'd7,  32'h0,         0, 0);
    run_op(32'h8000_0008, 32'h0,          4'b0010, 5'd8,  32'hCAFE_F00D, 5, 3);
    run_op(32'h8000_0002, 32'h0,          4'b0001, 5'd9,  32'h8001_7FFF, 1, 0);
    run_op(32'h8000_0002, 32'h0,          4'b0101, 5'd10, 32'h8001_7FFF, 0, 1);
    run_op(32'h8000_0001, 32'h0000_00A5,  4'b1000, 5'd11, 32'h0,         2, 0);
    run_op(32'h8000_000C, 32'h0BAD_CAFE,  4'b1010, 5'd12, 32'h0,         0, 2);

    for (int i = 0; i < 20; i++) begin
      run_op(32'h8000_0000 | ($urandom & 32'hFF), $urandom, 4'($urandom_range(0, 15)),
             5'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset during REQ: request must drop asynchronously and a late ack be ignored
    @(negedge clk);
    in_valid = 1'b1;
    addr_in  = 32'h8000_0010;
    lsu_op   = 4'b0010;
    rd_in    = 5'd13;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstreq_req", mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstreq_drop", mem_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    mem_ack = 1'b0;
    check("rstreq_no_valid", out_valid, 0);
    check("rstreq_idle", in_ready, 1);
    check("rstreq_no_req", mem_req, 0);
    @(negedge clk);
    check("rstreq_no_valid2", out_valid, 0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
